// File: rtl/keys_reader.sv
// rtl/keys_reader.sv - four-key debouncer with press/release strobes and auto-repeat
// Each key runs its own FSM behind a 2-flop synchronizer; counters stop at their compare values.
module keys_reader #(
  parameter logic [31:0] DEBOUNCE_TICKS     = 32'd1_000_000,
  parameter logic [31:0] REPEAT_DELAY_TICKS = 32'd25_000_000,
  parameter logic [31:0] REPEAT_RATE_TICKS  = 32'd5_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] keys_n,
  output logic [3:0] pressed,
  output logic [3:0] press_pulse,
  output logic [3:0] release_pulse,
  output logic [3:0] repeat_pulse
);

  typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_RELEASE} state_e;

  logic [3:0] sync1_q, sync2_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
    end else begin
      sync1_q <= keys_n;
      sync2_q <= sync1_q;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_key
    state_e      state_q, state_d;
    logic [31:0] deb_q, deb_d;
    logic [31:0] rep_q, rep_d;
    logic [31:0] rep_cmp;
    logic        rate_phase_q, rate_phase_d;
    logic        press_q, press_d;
    logic        rel_q, rel_d;
    logic        rpt_q, rpt_d;
    logic        sample;

    assign sample = sync2_q[g];

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        state_q      <= IDLE;
        deb_q        <= 32'd0;
        rep_q        <= 32'd0;
        rate_phase_q <= 1'b0;
        press_q      <= 1'b0;
        rel_q        <= 1'b0;
        rpt_q        <= 1'b0;
      end else begin
        state_q      <= state_d;
        deb_q        <= deb_d;
        rep_q        <= rep_d;
        rate_phase_q <= rate_phase_d;
        press_q      <= press_d;
        rel_q        <= rel_d;
        rpt_q        <= rpt_d;
      end
    end

    always_comb begin
      state_d      = state_q;
      deb_d        = deb_q;
      rep_d        = rep_q;
      rate_phase_d = rate_phase_q;
      press_d      = 1'b0;
      rel_d        = 1'b0;
      rpt_d        = 1'b0;
      // The first repeat waits the long delay; later ones use the rate.
      rep_cmp      = rate_phase_q ? (REPEAT_RATE_TICKS - 32'd1) : (REPEAT_DELAY_TICKS - 32'd1);
      case (state_q)
        IDLE: begin
          if (!sample) begin
            state_d = DEB_PRESS;
            deb_d   = 32'd0;
          end
        end
        DEB_PRESS: begin
          if (sample) begin
            state_d = IDLE;
            deb_d   = 32'd0;
          end else if (deb_q == DEBOUNCE_TICKS - 32'd1) begin
            state_d      = HELD;
            press_d      = 1'b1;
            deb_d        = 32'd0;
            rep_d        = 32'd0;
            rate_phase_d = 1'b0;
          end else begin
            deb_d = deb_q + 32'd1;
          end
        end
        HELD: begin
          if (sample) begin
            state_d = DEB_RELEASE;
            deb_d   = 32'd0;
          end else if (REPEAT_DELAY_TICKS != 32'd0) begin
            if (rep_q == rep_cmp) begin
              rep_d        = 32'd0;
              rate_phase_d = 1'b1;
              rpt_d        = 1'b1;
            end else begin
              rep_d = rep_q + 32'd1;
            end
          end
        end
        DEB_RELEASE: begin
          // Falling back to HELD leaves the repeat counter where it froze.
          if (!sample) begin
            state_d = HELD;
            deb_d   = 32'd0;
          end else if (deb_q == DEBOUNCE_TICKS - 32'd1) begin
            state_d = IDLE;
            rel_d   = 1'b1;
            deb_d   = 32'd0;
          end else begin
            deb_d = deb_q + 32'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    assign pressed[g]       = (state_q == HELD) || (state_q == DEB_RELEASE);
    assign press_pulse[g]   = press_q;
    assign release_pulse[g] = rel_q;
    assign repeat_pulse[g]  = rpt_q;
  end

endmodule

// File: tb/tb_keys_reader.sv
// tb/tb_keys_reader.sv - randomized and directed bench for keys_reader against a sample-history model
module tb_keys_reader;
  localparam int D    = 4;
  localparam int DLY  = 10;
  localparam int RATE = 5;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] keys_n = 4'hF;
  logic [3:0] pressed, press_pulse, release_pulse, repeat_pulse;

  keys_reader #(
    .DEBOUNCE_TICKS    (32'd4),
    .REPEAT_DELAY_TICKS(32'd10),
    .REPEAT_RATE_TICKS (32'd5)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .keys_n       (keys_n),
    .pressed      (pressed),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .repeat_pulse (repeat_pulse)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = -1;

  bit         m_lvl[4];
  int         m_run[4];
  int         m_hc[4];
  logic [3:0] m_s1, m_s2, m_pp, m_rr, m_rp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [3:0] m_pressed();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = m_lvl[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_lvl[i] = 1'b0;
      m_run[i] = 0;
      m_hc[i]  = 0;
    end
    m_s1 = 4'hF; m_s2 = 4'hF;
    m_pp = 4'h0; m_rr = 4'h0; m_rp = 4'h0;
  endtask

  // One clock edge: a key changes level after D+1 consecutive disagreeing samples;
  // repeats fall on held-cycle counts DLY, DLY+RATE, ... with release-glitch cycles excluded.
  task automatic model_edge(input logic [3:0] k);
    logic s;
    for (int i = 0; i < 4; i++) begin
      s = m_s2[i];
      m_pp[i] = 1'b0; m_rr[i] = 1'b0; m_rp[i] = 1'b0;
      if (!m_lvl[i]) begin
        if (!s) begin
          m_run[i]++;
          if (m_run[i] == D + 1) begin
            m_lvl[i] = 1'b1; m_run[i] = 0; m_hc[i] = 0; m_pp[i] = 1'b1;
          end
        end else m_run[i] = 0;
      end else begin
        if (s) begin
          m_run[i]++;
          if (m_run[i] == D + 1) begin
            m_lvl[i] = 1'b0; m_run[i] = 0; m_rr[i] = 1'b1;
          end
        end else begin
          if (m_run[i] == 0) begin
            m_hc[i]++;
            if (DLY != 0 && (m_hc[i] == DLY || (m_hc[i] > DLY && (m_hc[i] - DLY) % RATE == 0)))
              m_rp[i] = 1'b1;
          end
          m_run[i] = 0;
        end
      end
    end
    m_s2 = m_s1;
    m_s1 = k;
  endtask

  task automatic step(input logic [3:0] k);
    keys_n = k;
    @(posedge clock);
    #1;
    model_edge(k);
    cyc++;
    check("outputs", {16'h0, pressed, press_pulse, release_pulse, repeat_pulse},
          {16'h0, m_pressed(), m_pp, m_rr, m_rp});
  endtask

  int base, first, cnt, bad, pcyc, first_rep;

  initial begin
    model_reset();
    #2;
    check("reset_state", {16'h0, pressed, press_pulse, release_pulse, repeat_pulse}, 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Clean press on key 0, then hold for the repeat cadence.
    base = cyc + 1; first = -1;
    for (int n = 0; n < 12; n++) begin
      step(4'hE);
      if (press_pulse[0] && first < 0) first = cyc - base;
    end
    check("press_latency_k0", first, D + 2);
    pcyc = base + D + 2;
    cnt = 0; bad = 0; first_rep = -1;
    for (int n = 0; n < 40 && (cyc - pcyc) < 39; n++) begin
      step(4'hE);
      if (repeat_pulse[0]) begin
        cnt++;
        if (first_rep < 0) first_rep = cyc - pcyc;
        if ((cyc - pcyc) < DLY || ((cyc - pcyc) - DLY) % RATE != 0) bad++;
      end
    end
    check("repeat_first", first_rep, DLY);
    check("repeat_count", cnt, 6);
    check("repeat_phase", bad, 0);
    cnt = 0;
    for (int n = 0; n < 10; n++) begin
      step(4'hF);
      if (release_pulse[0]) cnt++;
    end
    check("release_k0", cnt, 1);

    // Bounce on key 1.
    cnt = 0;
    for (int n = 0; n < 3; n++) begin step(4'hD); if (press_pulse[1]) cnt++; end
    step(4'hF); if (press_pulse[1]) cnt++;
    base = cyc + 1; first = -1;
    for (int n = 0; n < 12; n++) begin
      step(4'hD);
      if (press_pulse[1]) begin
        if (first < 0) first = cyc - base;
        else cnt++;
      end
    end
    check("bounce_no_pulse", cnt, 0);
    check("press_latency_k1", first, D + 2);

    // Release glitch on key 1 while held.
    cnt = 0; bad = 0;
    step(4'hF); step(4'hF);
    for (int n = 0; n < 20; n++) begin
      step(4'hD);
      if (release_pulse[1]) cnt++;
      if (!pressed[1]) bad++;
    end
    check("glitch_no_release", cnt, 0);
    check("glitch_pressed_held", bad, 0);
    for (int n = 0; n < 10; n++) step(4'hF);

    // Reset while key 2 is held.
    for (int n = 0; n < 9; n++) step(4'hB);
    check("k2_pressed_before_reset", {31'h0, pressed[2]}, 32'h1);
    #2 reset = 1'b1;
    #1 check("reset_async", {16'h0, pressed, press_pulse, release_pulse, repeat_pulse}, 32'h0);
    model_reset();
    @(posedge clock); #1;
    check("reset_hold", {16'h0, pressed, press_pulse, release_pulse, repeat_pulse}, 32'h0);
    reset = 1'b0;
    base = cyc + 1; first = -1; cnt = 0;
    for (int n = 0; n < 12; n++) begin
      step(4'hB);
      if (press_pulse[2] && first < 0) first = cyc - base;
      if (release_pulse[2]) cnt++;
    end
    check("press_after_reset_k2", first, D + 2);
    check("no_release_on_reset", cnt, 0);
    for (int n = 0; n < 10; n++) step(4'hF);

    // All keys at once.
    cnt = 0; bad = 0;
    for (int n = 0; n < 10; n++) begin
      step(4'h0);
      if (press_pulse == 4'hF) cnt++;
      else if (press_pulse != 4'h0) bad++;
    end
    check("simul_press", cnt, 1);
    check("simul_press_partial", bad, 0);
    cnt = 0; bad = 0;
    for (int n = 0; n < 10; n++) begin
      step(4'hF);
      if (release_pulse == 4'hF) cnt++;
      else if (release_pulse != 4'h0) bad++;
    end
    check("simul_release", cnt, 1);
    check("simul_release_partial", bad, 0);

    // Random sticky key activity.
    begin
      logic [3:0] k;
      k = 4'hF;
      for (int n = 0; n < 3000; n++) begin
        for (int b = 0; b < 4; b++)
          if ($urandom_range(0, 9) == 0) k[b] = ~k[b];
        step(k);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/keys_reader.md
KEYS_READER -- requirements
Module: keys_reader

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_TICKS, default 32'd_1_000_000; stable-input cycles required to accept a press or release; legal range 1..2^32-1.
REQ-002 The block SHALL have parameter REPEAT_DELAY_TICKS, default 32'd_25_000_000; HELD cycles before the first repeat pulse; 0 disables repeat.
REQ-003 The block SHALL have parameter REPEAT_RATE_TICKS, default 32'd_5_000_000; cycles between subsequent repeat pulses; legal range 1..2^32-1.
REQ-004 The block SHALL have port clock, input, 1 bit; the single clock, with all flops on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit; asynchronous, active-high reset.
REQ-006 The block SHALL have port keys_n, input, 4 bits; raw push-buttons, active-low, asynchronous to clock, bouncing.
REQ-007 The block SHALL have port pressed, output, 4 bits; debounced key level, 1 = held.
REQ-008 The block SHALL have port press_pulse, output, 4 bits; one-cycle strobe on an accepted press.
REQ-009 The block SHALL have port release_pulse, output, 4 bits; one-cycle strobe on an accepted release.
REQ-010 The block SHALL have port repeat_pulse, output, 4 bits; one-cycle auto-repeat strobe while held.

Function
REQ-011 Each keys_n bit SHALL pass through a 2-flop synchronizer; its second-stage output is "sample".
REQ-012 The four keys SHALL be fully independent, each with its own FSM, 32-bit debounce counter and 32-bit repeat counter.
REQ-013 The per-key FSM SHALL have states IDLE, DEB_PRESS, HELD and DEB_RELEASE.
REQ-014 In IDLE, sample=0 SHALL move the FSM to DEB_PRESS with the debounce counter cleared; otherwise the FSM stays in IDLE.
REQ-015 In DEB_PRESS, sample=1 SHALL return the FSM to IDLE with the counter cleared and no pulse emitted.
REQ-016 In DEB_PRESS, with sample=0, the counter SHALL increment; when the counter equals DEBOUNCE_TICKS-1, the FSM SHALL enter HELD, pressed SHALL go to 1 and press_pulse SHALL be 1 for exactly one cycle.
REQ-017 Press latency SHALL be fixed: press_pulse asserts DEBOUNCE_TICKS+2 cycles after the first clock edge at which keys_n is sampled low, given keys_n then stays stable.
REQ-018 On entry to HELD, the repeat counter SHALL be cleared.
REQ-019 In HELD with REPEAT_DELAY_TICKS>0, repeat_pulse SHALL first assert after REPEAT_DELAY_TICKS cycles in HELD, then every REPEAT_RATE_TICKS cycles thereafter.
REQ-020 In HELD, sample=1 SHALL move the FSM to DEB_RELEASE with the debounce counter cleared; the repeat counter SHALL freeze and no repeat pulse SHALL occur.
REQ-021 In DEB_RELEASE, sample=0 SHALL return the FSM to HELD with the repeat counter resuming from its frozen value and no press_pulse emitted.
REQ-022 In DEB_RELEASE, with sample=1, when the counter equals DEBOUNCE_TICKS-1, the FSM SHALL enter IDLE, pressed SHALL go to 0 and release_pulse SHALL be 1 for exactly one cycle.
REQ-023 The pressed output SHALL stay 1 throughout HELD and DEB_RELEASE and SHALL be 0 in IDLE and DEB_PRESS.
REQ-024 press_pulse, release_pulse and repeat_pulse SHALL never be asserted in the same cycle for the same key.
REQ-025 All counters SHALL saturate rather than wrap; no counter SHALL exceed its compare value.
REQ-026 Multiple keys changing in the same cycle SHALL each produce their own pulses in the same cycles as if they had changed alone.

Reset
REQ-027 On reset, synchronizer flops SHALL be set to 1 (released), all FSMs SHALL be set to IDLE, all counters SHALL be set to 0, and pressed, press_pulse, release_pulse and repeat_pulse SHALL all be 4'b0000, effective immediately and independent of clock.
REQ-028 Reset asserted mid-debounce or while HELD SHALL drop pressed to 0 without a release_pulse.
REQ-029 After reset deassertion with a key already held low, a normal press SHALL be detected per REQ-017.

Verification
REQ-030 Clean press: DEBOUNCE_TICKS=4, REPEAT_DELAY_TICKS=0, keys_n[0] low at edge 0 and held -> press_pulse[0]=1 only at cycle 6, and pressed[0]=1 from cycle 6.
REQ-031 Bounce rejection: keys_n[1] low for 3 cycles, high for 1 cycle, then low and held (DEBOUNCE_TICKS=4) -> no pulse during the bounce; press_pulse[1] asserts 6 cycles after the final falling sample.
REQ-032 Repeat: DEBOUNCE_TICKS=4, REPEAT_DELAY_TICKS=10, REPEAT_RATE_TICKS=5, key held 40 cycles after press_pulse -> repeat_pulse at HELD cycles 10, 15, 20, 25, 30, 35 only.
REQ-033 Release glitch: while HELD, keys_n high for 2 cycles then low (DEBOUNCE_TICKS=4) -> no release_pulse, pressed stays 1, and the repeat cadence is shifted by the frozen cycles.
REQ-034 Reset mid-HELD: reset pulsed while pressed[2]=1 -> all outputs 0 immediately and no release_pulse; with the key still low, press_pulse[2] asserts DEBOUNCE_TICKS+2 cycles after reset release.
REQ-035 Simultaneous keys: keys_n=4'b0000 at the same edge -> press_pulse=4'b1111 in a single cycle, and later release_pulse=4'b1111 in a single cycle.
